// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with dead-time between digits.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GUARD_CYC = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic        load_ack,
  output logic [3:0]  caso,
  output logic [3:0]  digit_an,
  output logic        busy
);

  localparam int unsigned CW = ($clog2(SCAN_DIV) > 8) ? $clog2(SCAN_DIV) : 8;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_disp;
  logic          r_loaded;
  logic [3:0]    r_caso;
  logic [3:0]    r_an;
  logic          r_ack;
  logic          r_busy;

  logic [1:0]    w_state_nx;
  logic [1:0]    w_idx_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [15:0]   w_disp_nx;
  logic          w_enter_show;
  logic [3:0]    w_digit;

  // A load on the same edge as SHOW entry is used immediately by that visit.
  assign w_disp_nx    = load ? bcd_in : r_disp;
  assign w_enter_show = (w_state_nx == S_SHOW) && (r_state != S_SHOW);
  assign w_digit      = w_disp_nx[{w_idx_nx, 2'b00} +: 4];

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt + 1'b1;
    case (r_state)
      S_OFF: begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (enable && (load || r_loaded)) begin
          w_state_nx = S_SHOW;
        end
      end
      S_SHOW: begin
        if (!enable) begin
          w_state_nx = S_OFF;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end else if (r_cnt == SHOW_LAST) begin
          w_state_nx = S_GUARD;
          w_cnt_nx   = '0;
        end
      end
      S_GUARD: begin
        if (!enable) begin
          w_state_nx = S_OFF;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end else if (r_cnt == GUARD_LAST) begin
          w_state_nx = S_SHOW;
          w_cnt_nx   = '0;
          w_idx_nx   = r_idx + 2'd1;
        end
      end
      default: begin
        w_state_nx = S_OFF;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_blank;

  always_comb begin
    w_blank = 1'b0;
    if (w_idx_nx != 2'd0) begin
      w_blank = 1'b1;
      for (int unsigned k = 1; k < 4; k++) begin
        if ((k >= 32'(w_idx_nx)) && (w_disp_nx[k*4 +: 4] != 4'd0)) begin
          w_blank = 1'b0;
        end
      end
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state  <= S_OFF;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_disp   <= 16'hFFFF;
      r_loaded <= 1'b0;
      r_caso   <= 4'b1111;
      r_an     <= 4'b1111;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_ack   <= load;
      r_busy  <= (w_state_nx != S_OFF);
      if (load) begin
        r_disp   <= bcd_in;
        r_loaded <= 1'b1;
      end
      // Digit code is latched only on SHOW entry so a load never changes a lit digit.
      if (w_state_nx != S_SHOW) begin
        r_caso <= 4'b1111;
        r_an   <= 4'b1111;
      end else if (w_enter_show) begin
`ifdef LEADING_ZERO_BLANK_EN
        if (w_blank) begin
          r_caso <= 4'b1111;
          r_an   <= 4'b1111;
        end else begin
          r_caso <= w_digit;
          r_an   <= ~(4'b0001 << w_idx_nx);
        end
`else
        r_caso <= w_digit;
        r_an   <= ~(4'b0001 << w_idx_nx);
`endif
      end
    end
  end

  assign load_ack = r_ack;
  assign caso     = r_caso;
  assign digit_an = r_an;
  assign busy     = r_busy;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (SCAN_DIV=4, GUARD_CYC=2).
module tb_display_scan_ctrl;

  localparam int unsigned S = 4;
  localparam int unsigned G = 2;
  localparam int unsigned P = S + G;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] bcd_in   = '0;
  logic        load_ack;
  logic [3:0]  caso;
  logic [3:0]  digit_an;
  logic        busy;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.SCAN_DIV(S), .GUARD_CYC(G)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable), .load(load),
    .bcd_in(bcd_in), .load_ack(load_ack), .caso(caso), .digit_an(digit_an),
    .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: scan position as elapsed time since the scan started.
  logic        m_on = 1'b0;
  int unsigned m_t = 0;
  logic [15:0] m_disp = 16'hFFFF;
  logic [15:0] m_lat = 16'hFFFF;
  logic        m_loaded = 1'b0;
  logic [3:0]  e_caso, e_an;
  logic        e_ack, e_busy;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rst, en, ld, input logic [15:0] bcd);
    int unsigned ph, dg;
    if (!rst) begin
      m_on = 1'b0; m_disp = 16'hFFFF; m_loaded = 1'b0; e_ack = 1'b0;
    end else begin
      e_ack = ld;
      if (ld) begin m_disp = bcd; m_loaded = 1'b1; end
      if (m_on) begin
        if (!en) m_on = 1'b0; else m_t++;
      end else if (en && m_loaded) begin
        m_on = 1'b1; m_t = 0;
      end
    end
    e_caso = 4'hF; e_an = 4'hF; e_busy = m_on;
    if (m_on) begin
      ph = m_t % P;
      dg = (m_t / P) % 4;
      if (ph == 0) m_lat = m_disp;
      if (ph < S) begin
        e_caso = 4'((m_lat >> (4 * dg)) & 16'hF);
        e_an   = 4'(~(1 << dg));
`ifdef LEADING_ZERO_BLANK_EN
        if (dg >= 1 && (m_lat >> (4 * dg)) == 16'h0) begin
          e_caso = 4'hF; e_an = 4'hF;
        end
`endif
      end
    end
  endtask

  task automatic step(input logic rst, en, ld, input logic [15:0] bcd);
    reset_n = rst; enable = en; load = ld; bcd_in = bcd;
    @(posedge CLOCK_50); #1;
    model(rst, en, ld, bcd);
    check("model_caso", {12'h0, caso}, {12'h0, e_caso});
    check("model_an", {12'h0, digit_an}, {12'h0, e_an});
    check("model_ack", {15'h0, load_ack}, {15'h0, e_ack});
    check("model_busy", {15'h0, busy}, {15'h0, e_busy});
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b1, en, 1'b0, 16'h0);
  endtask

  typedef struct {
    logic        rst_n, en, ld;
    logic [15:0] bcd;
    logic [3:0]  caso, an;
    logic        ack, busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int seq_c[9]   = '{4'h1, 4'hF, 4'h2, 4'hF, 4'h3, 4'hF, 4'h4, 4'hF, 4'h1};
    int seq_a[9]   = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
    int seq_len[9] = '{S, G, S, G, S, G, S, G, S};
    logic [3:0] e0;

    // Reset held 3 cycles, 20 idle cycles, then load 4321 and a full scan.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 16'h0, 4'hF, 4'hF, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 16'h0, 4'hF, 4'hF, 1'b0, 1'b0});
    for (int s = 0; s < 9; s++)
      for (int i = 0; i < seq_len[s]; i++)
        tbl.push_back('{1'b1, 1'b1, (s == 0 && i == 0), 16'h4321,
                        4'(seq_c[s]), 4'(seq_a[s]), (s == 0 && i == 0), 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].ld, tbl[i].bcd);
      check("tbl_caso", {12'h0, caso}, {12'h0, tbl[i].caso});
      check("tbl_an", {12'h0, digit_an}, {12'h0, tbl[i].an});
      check("tbl_ack", {15'h0, load_ack}, {15'h0, tbl[i].ack});
      check("tbl_busy", {15'h0, busy}, {15'h0, tbl[i].busy});
    end

    // Drop enable mid-SHOW of digit 2, then re-enable.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h4321);
    idle(13, 1'b1);
    check("d2_lit", {12'h0, digit_an}, 16'h000B);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    check("drop_an", {12'h0, digit_an}, 16'h000F);
    check("drop_busy", {15'h0, busy}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("resume_caso", {12'h0, caso}, 16'h0001);
    check("resume_an", {12'h0, digit_an}, 16'h000E);

    // Load during SHOW of digit 1: takes effect at the next digit 1 visit.
    idle(6, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0070);
    check("mid_caso_old", {12'h0, caso}, 16'h0002);
    check("mid_ack", {15'h0, load_ack}, 16'h0001);
    idle(2, 1'b1);
    check("mid_hold", {12'h0, caso}, 16'h0002);
    idle(21, 1'b1);
    check("new_d1_caso", {12'h0, caso}, 16'h0007);
    check("new_d1_an", {12'h0, digit_an}, 16'h000D);

    // Leading-zero handling for 0005.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0005);
    check("z_d0", {12'h0, caso}, 16'h0005);
    for (int d = 1; d < 4; d++) begin
      idle(P, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
      e0 = 4'hF;
      check("z_an", {12'h0, digit_an}, 16'h000F);
`else
      e0 = 4'h0;
      check("z_an", {12'h0, digit_an}, {12'h0, 4'(~(1 << d))});
`endif
      check("z_caso", {12'h0, caso}, {12'h0, e0});
      check("z_busy", {15'h0, busy}, 16'h0001);
    end

    // Reset during GUARD takes priority over load and enable.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h9999);
    idle(4, 1'b1);
    check("g_busy", {15'h0, busy}, 16'h0001);
    check("g_an", {12'h0, digit_an}, 16'h000F);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check("rst_an", {12'h0, digit_an}, 16'h000F);
    check("rst_ack", {15'h0, load_ack}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    idle(6, 1'b1);
    check("post_rst_off", {15'h0, busy}, 16'h0000);
    check("post_rst_caso", {12'h0, caso}, 16'h000F);

    // Load/GUARD-entry coincidence.
    step(1'b1, 1'b1, 1'b1, 16'h8765);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h2222);
    check("coin_ack", {15'h0, load_ack}, 16'h0001);
    check("coin_guard", {12'h0, digit_an}, 16'h000F);
    idle(2, 1'b1);
    check("coin_new", {12'h0, caso}, 16'h0002);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 9) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
